// File: rtl/canonical_huffman_decoder_pkg.sv
// Shared widths and state encoding for the canonical Huffman decoder slice.
package huffman_pkg;

  localparam int unsigned SYM_W  = 8;
  localparam int unsigned NSYM   = 16;
  localparam int unsigned MAXLEN = 8;
  localparam int unsigned CNT_W  = $clog2(NSYM) + 1;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned IDX_W  = $clog2(NSYM);
  localparam int unsigned CODE_W = MAXLEN + 1;
  localparam int unsigned SUM_W  = CODE_W + 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DECODE = 2'd1,
    OUT    = 2'd2,
    ERR    = 2'd3
  } state_t;

endpackage

// File: rtl/canonical_huffman_decoder_if.sv
// Table-load, bit-stream and symbol-output signals of the Huffman decoder.
interface canonical_huffman_decoder_if;
  import huffman_pkg::*;

  logic              flush;
  logic              tbl_wr_en;
  logic              tbl_wr_sel;
  logic [ADDR_W-1:0] tbl_wr_addr;
  logic [SYM_W-1:0]  tbl_wr_data;
  logic              tbl_done;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [SYM_W-1:0]  sym_out;
  logic [LEN_W-1:0]  sym_len;
  logic              sym_valid;
  logic              sym_ready;
  logic              err;
  logic              busy;

  modport master (
    output flush, tbl_wr_en, tbl_wr_sel, tbl_wr_addr, tbl_wr_data, tbl_done,
    output bit_in, bit_valid, sym_ready,
    input  bit_ready, sym_out, sym_len, sym_valid, err, busy
  );

  modport slave (
    input  flush, tbl_wr_en, tbl_wr_sel, tbl_wr_addr, tbl_wr_data, tbl_done,
    input  bit_in, bit_valid, sym_ready,
    output bit_ready, sym_out, sym_len, sym_valid, err, busy
  );

endinterface

// File: rtl/canonical_huffman_decoder_table.sv
// Per-length code count table and canonical-order symbol table with
// one write port and combinational read ports.
module huff_code_table
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_data,
  input  logic [LEN_W-1:0]  cnt_addr,
  output logic [CNT_W-1:0]  cnt_rd_c,
  input  logic [IDX_W-1:0]  sym_addr,
  output logic [SYM_W-1:0]  sym_rd_c
);

  logic [CNT_W-1:0] cnt_q [MAXLEN+1];
  logic [SYM_W-1:0] sym_q [NSYM];
  logic             cnt_we;
  logic             sym_we;

  // Length 0 has no codes, so address 0 is never written.
  assign cnt_we = wr_en && !wr_sel && (wr_addr != '0) && (wr_addr <= ADDR_W'(MAXLEN));
  assign sym_we = wr_en && wr_sel && (32'(wr_addr) < NSYM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= MAXLEN; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i <= MAXLEN; i++) cnt_q[i] <= '0;
    end else if (cnt_we) begin
      cnt_q[wr_addr] <= CNT_W'(wr_data);
    end
  end

  // Symbol storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (sym_we) sym_q[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  assign cnt_rd_c = (cnt_addr <= LEN_W'(MAXLEN)) ? cnt_q[cnt_addr] : '0;
  assign sym_rd_c = sym_q[sym_addr];

endmodule

// File: rtl/canonical_huffman_decoder.sv
// Bit-serial canonical Huffman decoder: loads count/symbol tables, then
// decodes one bit per cycle and hands symbols out over valid/ready.
module canonical_huffman_decoder
  import huffman_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  canonical_huffman_decoder_if.slave   bus
);

  state_t            state, state_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [CODE_W-1:0] first_q, first_n;
  logic [CNT_W-1:0]  index_q, index_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [SYM_W-1:0]  sym_out_q, sym_out_n;
  logic [LEN_W-1:0]  sym_len_q, sym_len_n;
  logic              sym_valid_q, sym_valid_n;
  logic              err_q, err_n;
  logic              bit_ready_q, bit_ready_n;
  logic              busy_q, busy_n;

  logic [CODE_W-1:0] code_c;
  logic [CODE_W-1:0] diff_c;
  logic [LEN_W-1:0]  len_c;
  logic [CNT_W-1:0]  cnt_c;
  logic [SUM_W-1:0]  sum_c;
  logic [SYM_W-1:0]  sym_c;
  logic              hit_c;
  logic              tbl_we_c;

  assign tbl_we_c = bus.tbl_wr_en && (state == LOAD) && !bus.flush;

  huff_code_table u_table (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.flush),
    .wr_en    (tbl_we_c),
    .wr_sel   (bus.tbl_wr_sel),
    .wr_addr  (bus.tbl_wr_addr),
    .wr_data  (bus.tbl_wr_data),
    .cnt_addr (len_c),
    .cnt_rd_c (cnt_c),
    .sym_addr (sum_c[IDX_W-1:0]),
    .sym_rd_c (sym_c)
  );

  // Candidate code with the incoming bit; a hit needs an in-range symbol index too.
  assign code_c = CODE_W'({code_q, bus.bit_in});
  assign len_c  = len_q + LEN_W'(1);
  assign diff_c = code_c - first_q;
  assign sum_c  = SUM_W'(index_q) + SUM_W'(diff_c);
  assign hit_c  = (diff_c < CODE_W'(cnt_c)) && (sum_c < SUM_W'(NSYM));

  always_comb begin
    state_n     = state;
    code_n      = code_q;
    first_n     = first_q;
    index_n     = index_q;
    len_n       = len_q;
    sym_out_n   = sym_out_q;
    sym_len_n   = sym_len_q;
    sym_valid_n = sym_valid_q;
    err_n       = err_q;

    if (bus.flush) begin
      state_n     = LOAD;
      err_n       = 1'b0;
      sym_valid_n = 1'b0;
      code_n      = '0;
      first_n     = '0;
      index_n     = '0;
      len_n       = '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.tbl_done) begin
            state_n = DECODE;
            code_n  = '0;
            first_n = '0;
            index_n = '0;
            len_n   = '0;
          end
        end
        DECODE: begin
          if (bus.bit_valid && bit_ready_q) begin
            if (hit_c) begin
              sym_out_n   = sym_c;
              sym_len_n   = len_c;
              sym_valid_n = 1'b1;
              state_n     = OUT;
            end else if (len_c == LEN_W'(MAXLEN)) begin
              err_n   = 1'b1;
              state_n = ERR;
            end else begin
              index_n = index_q + cnt_c;
              first_n = CODE_W'((first_q + CODE_W'(cnt_c)) << 1);
              code_n  = code_c;
              len_n   = len_c;
            end
          end
        end
        OUT: begin
          if (bus.sym_ready) begin
            sym_valid_n = 1'b0;
            state_n     = DECODE;
            code_n      = '0;
            first_n     = '0;
            index_n     = '0;
            len_n       = '0;
          end
        end
        ERR: begin
          state_n = ERR;
        end
        default: state_n = LOAD;
      endcase
    end

    bit_ready_n = (state_n == DECODE);
    busy_n      = (state_n != LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= '0;
      sym_out_q   <= '0;
      sym_len_q   <= '0;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      code_q      <= code_n;
      first_q     <= first_n;
      index_q     <= index_n;
      len_q       <= len_n;
      sym_out_q   <= sym_out_n;
      sym_len_q   <= sym_len_n;
      sym_valid_q <= sym_valid_n;
      err_q       <= err_n;
      bit_ready_q <= bit_ready_n;
      busy_q      <= busy_n;
    end
  end

  assign bus.sym_out   = sym_out_q;
  assign bus.sym_len   = sym_len_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.err       = err_q;
  assign bus.bit_ready = bit_ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// Directed self-checking bench for canonical_huffman_decoder.
module tb_canonical_huffman_decoder;
  import huffman_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  canonical_huffman_decoder_if bus ();

  canonical_huffman_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [SYM_W-1:0] data,
                    input logic done);
    bus.tbl_wr_en   = 1'b1;
    bus.tbl_wr_sel  = sel;
    bus.tbl_wr_addr = addr;
    bus.tbl_wr_data = data;
    bus.tbl_done    = done;
    tick();
    bus.tbl_wr_en   = 1'b0;
    bus.tbl_done    = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tbl_done = 1'b1;
    tick();
    bus.tbl_done = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  // Counts 1/1/2 for lengths 1..3; the last symbol write shares its cycle with tbl_done.
  task automatic load_basic();
    wr(1'b0, 4'd1, 8'd1, 1'b0);
    wr(1'b0, 4'd2, 8'd1, 1'b0);
    wr(1'b0, 4'd3, 8'd2, 1'b0);
    wr(1'b1, 4'd0, 8'd41, 1'b0);
    wr(1'b1, 4'd1, 8'd42, 1'b0);
    wr(1'b1, 4'd2, 8'd43, 1'b0);
    wr(1'b1, 4'd3, 8'd44, 1'b1);
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    while (bus.bit_ready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if (bus.bit_ready !== 1'b1) begin
      fails++;
      $display("FAIL bit_accept: bit_ready=%b required 1 within 16 cycles", bus.bit_ready);
    end
    tick();
    bus.bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks += 6;
    if (bus.sym_valid !== 1'b0) begin fails++; $display("FAIL reset_sym_valid: got %b required 0", bus.sym_valid); end
    if (bus.sym_out !== 8'd0) begin fails++; $display("FAIL reset_sym_out: got %0d required 0", bus.sym_out); end
    if (bus.sym_len !== 4'd0) begin fails++; $display("FAIL reset_sym_len: got %0d required 0", bus.sym_len); end
    if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", bus.err); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    if (bus.bit_ready !== 1'b0) begin fails++; $display("FAIL reset_bit_ready: got %b required 0", bus.bit_ready); end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int          len_tab [4] = '{1, 2, 3, 3};
    logic [2:0]  code_tab[4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [2:0]  cw;
    bus.sym_ready = 1'b1;
    load_basic();
    checks += 2;
    if (bus.bit_ready !== 1'b1) begin fails++; $display("FAIL basic_enter_decode: bit_ready=%b required 1", bus.bit_ready); end
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b required 1", bus.busy); end
    for (int k = 0; k < 4; k++) begin
      cw = code_tab[k];
      for (int j = len_tab[k] - 1; j >= 0; j--) begin
        send_bit(cw[j]);
        if (j > 0) begin
          checks++;
          if (bus.sym_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: sym %0d got %b required 0", k, bus.sym_valid); end
        end
      end
      checks += 3;
      if (bus.sym_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: sym %0d got %b required 1", k, bus.sym_valid); end
      if (bus.sym_out !== 8'(41 + k)) begin fails++; $display("FAIL basic_sym: got %0d required %0d", bus.sym_out, 41 + k); end
      if (bus.sym_len !== 4'(len_tab[k])) begin fails++; $display("FAIL basic_len: got %0d required %0d", bus.sym_len, len_tab[k]); end
      tick();
      checks += 2;
      if (bus.sym_valid !== 1'b0) begin fails++; $display("FAIL basic_handshake: sym_valid=%b required 0", bus.sym_valid); end
      if (bus.bit_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_again: bit_ready=%b required 1", bus.bit_ready); end
    end
  endtask

  task automatic test_backpressure();
    bus.sym_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    checks += 2;
    if (bus.sym_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b required 1", bus.sym_valid); end
    if (bus.sym_out !== 8'd42) begin fails++; $display("FAIL bp_sym: got %0d required 42", bus.sym_out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 4;
      if (bus.sym_out !== 8'd42) begin fails++; $display("FAIL bp_hold_sym: cycle %0d got %0d required 42", i, bus.sym_out); end
      if (bus.sym_len !== 4'd2) begin fails++; $display("FAIL bp_hold_len: cycle %0d got %0d required 2", i, bus.sym_len); end
      if (bus.sym_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid: cycle %0d got %b required 1", i, bus.sym_valid); end
      if (bus.bit_ready !== 1'b0) begin fails++; $display("FAIL bp_bit_ready: cycle %0d got %b required 0", i, bus.bit_ready); end
    end
    bus.sym_ready = 1'b1;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b1;
    tick();
    checks += 2;
    if (bus.sym_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b required 0", bus.sym_valid); end
    if (bus.bit_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b required 1", bus.bit_ready); end
    tick();
    bus.bit_valid = 1'b0;
    checks += 2;
    if (bus.sym_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid: got %b required 1", bus.sym_valid); end
    if (bus.sym_out !== 8'd41) begin fails++; $display("FAIL bp_next_sym: got %0d required 41", bus.sym_out); end
    tick();
  endtask

  task automatic test_write_gating();
    wr(1'b1, 4'd0, 8'd99, 1'b0);
    send_bit(1'b0);
    checks += 3;
    if (bus.sym_valid !== 1'b1) begin fails++; $display("FAIL gate_valid: got %b required 1", bus.sym_valid); end
    if (bus.sym_out !== 8'd41) begin fails++; $display("FAIL gate_sym: got %0d required 41", bus.sym_out); end
    if (bus.sym_len !== 4'd1) begin fails++; $display("FAIL gate_len: got %0d required 1", bus.sym_len); end
    tick();
  endtask

  task automatic test_invalid();
    logic seen = 1'b0;
    pulse_flush();
    checks += 2;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL inv_flush_busy: got %b required 0", bus.busy); end
    if (bus.bit_ready !== 1'b0) begin fails++; $display("FAIL inv_flush_ready: got %b required 0", bus.bit_ready); end
    wr(1'b0, 4'd1, 8'd1, 1'b0);
    wr(1'b1, 4'd0, 8'd55, 1'b0);
    pulse_done();
    bus.sym_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      if (bus.sym_valid === 1'b1) seen = 1'b1;
      if (i == 6) begin
        checks++;
        if (bus.err !== 1'b0) begin fails++; $display("FAIL inv_err_early: after 7 bits got %b required 0", bus.err); end
      end
    end
    checks += 4;
    if (bus.err !== 1'b1) begin fails++; $display("FAIL inv_err: got %b required 1", bus.err); end
    if (bus.bit_ready !== 1'b0) begin fails++; $display("FAIL inv_bit_ready: got %b required 0", bus.bit_ready); end
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL inv_busy: got %b required 1", bus.busy); end
    if (seen !== 1'b0) begin fails++; $display("FAIL inv_no_symbol: sym_valid seen=%b required 0", seen); end
    tick();
    tick();
    checks += 2;
    if (bus.err !== 1'b1) begin fails++; $display("FAIL inv_err_sticky: got %b required 1", bus.err); end
    if (bus.sym_valid !== 1'b0) begin fails++; $display("FAIL inv_sym_valid: got %b required 0", bus.sym_valid); end
    pulse_flush();
    checks += 3;
    if (bus.err !== 1'b0) begin fails++; $display("FAIL inv_flush_err: got %b required 0", bus.err); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL inv_flush_load: busy=%b required 0", bus.busy); end
    if (bus.bit_ready !== 1'b0) begin fails++; $display("FAIL inv_flush_bit_ready: got %b required 0", bus.bit_ready); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    int   nbits = 0;
    pulse_flush();
    bus.sym_ready = 1'b1;
    load_basic();
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (bus.sym_out !== 8'd42) begin fails++; $display("FAIL rmid_setup_sym: got %0d required 42", bus.sym_out); end
    tick();
    send_bit(1'b1);
    send_bit(1'b1);
    #2 rst = 1'b1;
    #1;
    checks += 6;
    if (bus.sym_out !== 8'd0) begin fails++; $display("FAIL rmid_sym_out: got %0d required 0", bus.sym_out); end
    if (bus.sym_len !== 4'd0) begin fails++; $display("FAIL rmid_sym_len: got %0d required 0", bus.sym_len); end
    if (bus.sym_valid !== 1'b0) begin fails++; $display("FAIL rmid_sym_valid: got %b required 0", bus.sym_valid); end
    if (bus.err !== 1'b0) begin fails++; $display("FAIL rmid_err: got %b required 0", bus.err); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b required 0", bus.busy); end
    if (bus.bit_ready !== 1'b0) begin fails++; $display("FAIL rmid_bit_ready: got %b required 0", bus.bit_ready); end
    tick();
    rst = 1'b0;
    tick();
    pulse_done();
    checks++;
    if (bus.bit_ready !== 1'b1) begin fails++; $display("FAIL rmid_decode: bit_ready=%b required 1", bus.bit_ready); end
    while (bus.err !== 1'b1 && nbits < int'(MAXLEN)) begin
      send_bit(1'b1);
      if (bus.sym_valid === 1'b1) seen = 1'b1;
      nbits++;
    end
    checks += 2;
    if (bus.err !== 1'b1) begin fails++; $display("FAIL rmid_err_empty_table: got %b required 1", bus.err); end
    if (seen !== 1'b0) begin fails++; $display("FAIL rmid_no_symbol: sym_valid seen=%b required 0", seen); end
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.tbl_wr_en   = 1'b0;
    bus.tbl_wr_sel  = 1'b0;
    bus.tbl_wr_addr = '0;
    bus.tbl_wr_data = '0;
    bus.tbl_done    = 1'b0;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.sym_ready   = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_write_gating();
    test_invalid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
